// File: rtl/mac_seq.sv
// mac_seq -- two-stage (E, W) command sequencer for a multiply-accumulate
// datapath. Commands are accepted on a valid/ready handshake, decoded in the
// E stage into multiplier-array controls, and in the W stage into final-adder
// and MR-register write controls. SAT holds the W stage for two cycles:
// SAT1 evaluates and SAT2 writes back the saturated value.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   cmd_vld/rdy     command handshake (accept when both are high)
//   cmd_op[2:0]     000 NOP, 001 MPY, 010 MAC, 011 MSB, 100 CLR, 101 SAT,
//                   11x reserved (treated as NOP)
//   cmd_tag[3:0]    opaque tag, returned on done_tag
//   hold            stall: freezes the stages and the FSM, masks the enables
//   mv_in           adder overflow, valid while an op is in W
//   mv_clr          software clear of the sticky overflow flag
//   arr_en/arr_sub  E-stage array enable / product negate
//   arr_mrsel[1:0]  MR feedback select: 00 zero, 01 MR reg, 10 forwarded W
//   add_en, mr_we   W-stage adder enable / MR write enable
//   mr_sat          select the saturated value on the MR write path
//   mv              sticky overflow flag
//   done_vld/tag    one-cycle completion pulse and its tag
//   busy            a stage is occupied or the FSM is not IDLE
module mac_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_tag,
  input  logic       hold,
  input  logic       mv_in,
  input  logic       mv_clr,
  output logic       arr_en,
  output logic       arr_sub,
  output logic [1:0] arr_mrsel,
  output logic       add_en,
  output logic       mr_we,
  output logic       mr_sat,
  output logic       mv,
  output logic       done_vld,
  output logic [3:0] done_tag,
  output logic       busy
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_MPY = 3'b001,
    OP_MAC = 3'b010,
    OP_MSB = 3'b011,
    OP_CLR = 3'b100,
    OP_SAT = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT1 = 2'd2,
    S_SAT2 = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       e_vld, w_vld;
  op_t        e_op, w_op;
  logic [3:0] e_tag, w_tag;
  op_t        cmd_op_n;
  logic       accept, advance, sat_in_flight;
  logic       e_arith, w_arith, w_mr_op;
  logic       mv_set, mv_reset;

  // Reserved opcodes collapse to NOP before they enter the pipeline, so the
  // stage decoders only ever see legal values.
  assign cmd_op_n = (cmd_op[2:1] == 2'b11) ? OP_NOP : op_t'(cmd_op);

  assign sat_in_flight = (e_vld && e_op == OP_SAT) || (w_vld && w_op == OP_SAT);

  // Gated with rst_n so ready is low for the whole reset window and rises in
  // the first cycle after release.
  assign cmd_rdy = rst_n && !hold && !sat_in_flight &&
                   (state == S_IDLE || state == S_RUN);
  assign accept  = cmd_vld && cmd_rdy;

  // W is pinned during SAT1; in SAT2 the SAT leaves W and the (empty) E stage
  // moves up behind it.
  assign advance = !hold && (state != S_SAT1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only control state is reset here; there is no storage array in
      // this block, so every flop can be cleared cheaply and deterministically.
      e_vld <= 1'b0;
      e_op  <= OP_NOP;
      e_tag <= '0;
      w_vld <= 1'b0;
      w_op  <= OP_NOP;
      w_tag <= '0;
    end else if (advance) begin
      w_vld <= e_vld;
      w_op  <= e_op;
      w_tag <= e_tag;
      e_vld <= accept;
      e_op  <= accept ? cmd_op_n : OP_NOP;
      e_tag <= accept ? cmd_tag  : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (!hold) begin
      unique case (state)
        S_IDLE: if (accept) state_nxt = S_RUN;
        S_RUN: begin
          if (e_vld && e_op == OP_SAT)         state_nxt = S_SAT1;
          else if (!e_vld && !w_vld && !accept) state_nxt = S_IDLE;
        end
        S_SAT1: state_nxt = S_SAT2;
        // The SAT leaves W at the end of SAT2, so only E can still be occupied.
        S_SAT2: state_nxt = e_vld ? S_RUN : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign e_arith = e_vld && (e_op == OP_MPY || e_op == OP_MAC || e_op == OP_MSB);
  assign w_arith = w_vld && (w_op == OP_MPY || w_op == OP_MAC || w_op == OP_MSB);
  // Ops whose W-stage result lands in MR and can therefore be forwarded.
  assign w_mr_op = w_arith || (w_vld && w_op == OP_CLR);

  // E-stage decode: stage registers and hold only, never cmd_*.
  assign arr_en  = !hold && e_arith;
  assign arr_sub = e_vld && e_op == OP_MSB;
  always_comb begin
    arr_mrsel = 2'b00;
    if (e_vld && (e_op == OP_MAC || e_op == OP_MSB))
      arr_mrsel = w_mr_op ? 2'b10 : 2'b01;
  end

  // W-stage decode.
  assign add_en   = !hold && w_arith;
  assign mr_sat   = !hold && w_vld && w_op == OP_SAT && state == S_SAT2;
  assign mr_we    = !hold && (w_mr_op || mr_sat);
  assign done_vld = !hold && w_vld && (w_op != OP_SAT || state == S_SAT2);
  assign done_tag = done_vld ? w_tag : 4'd0;
  assign busy     = e_vld || w_vld || (state != S_IDLE);

  // Sticky overflow: set has priority over either clear source.
  assign mv_set   = !hold && w_arith && mv_in;
  assign mv_reset = mv_clr || (!hold && w_vld && w_op == OP_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mv <= 1'b0;
    else if (mv_set)   mv <= 1'b1;
    else if (mv_reset) mv <= 1'b0;
  end

endmodule

// File: tb/tb_mac_seq.sv
// Directed testbench for mac_seq. Inputs are driven 1 time unit after the
// rising edge and outputs are compared 1 time unit later, away from the edge.
module tb_mac_seq;

  localparam logic [2:0] NOP = 3'b000, MPY = 3'b001, MAC = 3'b010,
                         MSB = 3'b011, CLR = 3'b100, SAT = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [2:0] cmd_op;
  logic [3:0] cmd_tag;
  logic       hold, mv_in, mv_clr;
  logic       arr_en, arr_sub, add_en, mr_we, mr_sat, mv, done_vld, busy;
  logic [1:0] arr_mrsel;
  logic [3:0] done_tag;

  int n_vec = 0;
  int n_err = 0;

  mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .hold      (hold),
    .mv_in     (mv_in),
    .mv_clr    (mv_clr),
    .arr_en    (arr_en),
    .arr_sub   (arr_sub),
    .arr_mrsel (arr_mrsel),
    .add_en    (add_en),
    .mr_we     (mr_we),
    .mr_sat    (mr_sat),
    .mv        (mv),
    .done_vld  (done_vld),
    .done_tag  (done_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic vld, input logic [2:0] op, input logic [3:0] tag);
    cmd_vld = vld;
    cmd_op  = op;
    cmd_tag = tag;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; mv_in = 1'b0; mv_clr = 1'b0;
    cmd(1'b1, MPY, 4'd3);   // driven during reset: must not be accepted

    // Reset state
    #2;
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_done_vld", done_vld, 0);
    check("rst_arr_mrsel", arr_mrsel, 0);
    check("rst_mv", mv, 0);
    cyc(); cyc();
    rst_n = 1'b1; #1;
    check("rdy_after_release", cmd_rdy, 1);

    // MPY tag 3 accepted in cycle 0, with overflow in W
    check("mpy_busy_c0", busy, 0);
    cyc(); cmd(1'b0, NOP, 4'd0); #1;
    check("mpy_arr_en_c1", arr_en, 1);
    check("mpy_mrsel_c1", arr_mrsel, 0);
    check("mpy_add_en_c1", add_en, 0);
    check("mpy_busy_c1", busy, 1);
    cyc(); mv_in = 1'b1; #1;
    check("mpy_add_en_c2", add_en, 1);
    check("mpy_mr_we_c2", mr_we, 1);
    check("mpy_done_c2", done_vld, 1);
    check("mpy_tag_c2", done_tag, 3);
    cyc(); mv_in = 1'b0; cmd(1'b1, CLR, 4'd4); #1;
    check("mv_set", mv, 1);

    // CLR completes and clears MV
    cyc(); cmd(1'b0, NOP, 4'd0); #1;
    check("clr_e_arr_en", arr_en, 0);
    cyc(); #1;
    check("clr_mr_we", mr_we, 1);
    check("clr_add_en", add_en, 0);
    check("clr_tag", done_tag, 4);
    cyc(); cmd(1'b1, MPY, 4'd1); #1;
    check("mv_cleared_by_clr", mv, 0);

    // MPY then MAC back-to-back: forwarding; MV set and clear together
    cyc(); cmd(1'b1, MAC, 4'd2); #1;
    check("b2b_rdy", cmd_rdy, 1);
    cyc(); cmd(1'b0, NOP, 4'd0); mv_in = 1'b1; mv_clr = 1'b1; #1;
    check("b2b_mrsel_fwd", arr_mrsel, 2'b10);
    check("b2b_arr_en", arr_en, 1);
    check("b2b_tag1", done_tag, 1);
    cyc(); mv_in = 1'b0; #1;
    check("mv_set_wins", mv, 1);
    check("b2b_tag2", done_tag, 2);
    cyc(); mv_clr = 1'b0; #1;
    check("mv_sw_clear", mv, 0);

    // One-cycle gap: MAC reads MR register; MSB behind it forwards
    cmd(1'b1, MPY, 4'd1);
    cyc(); cmd(1'b0, NOP, 4'd0);
    cyc(); cmd(1'b1, MAC, 4'd2);
    cyc(); cmd(1'b1, MSB, 4'd9); #1;
    check("gap_mrsel_mr", arr_mrsel, 2'b01);
    check("gap_arr_sub", arr_sub, 0);
    cyc(); cmd(1'b0, NOP, 4'd0); #1;
    check("msb_arr_sub", arr_sub, 1);
    check("msb_mrsel_fwd", arr_mrsel, 2'b10);
    cyc(); #1;
    check("msb_tag", done_tag, 9);
    check("msb_mr_we", mr_we, 1);
    cyc(); cyc(); #1;
    check("idle_busy", busy, 0);

    // MAC tag 6 with HOLD for 3 cycles while in E
    cmd(1'b1, MAC, 4'd6);
    cyc(); cmd(1'b0, NOP, 4'd0); hold = 1'b1; #1;
    check("hold_arr_en", arr_en, 0);
    check("hold_rdy", cmd_rdy, 0);
    cyc(); #1;
    check("hold_done_2", done_vld, 0);
    cyc(); #1;
    check("hold_done_3", done_vld, 0);
    cyc(); hold = 1'b0; #1;
    check("resume_arr_en", arr_en, 1);
    check("resume_done", done_vld, 0);
    cyc(); #1;
    check("hold_done_late", done_vld, 1);
    check("hold_tag", done_tag, 6);

    // SAT tag 5 followed by a pending MAC tag 7
    cmd(1'b1, SAT, 4'd5);
    cyc(); cmd(1'b1, MAC, 4'd7); #1;
    check("sat_e_rdy", cmd_rdy, 0);
    cyc(); #1;
    check("sat1_rdy", cmd_rdy, 0);
    check("sat1_mr_we", mr_we, 0);
    check("sat1_mr_sat", mr_sat, 0);
    check("sat1_done", done_vld, 0);
    cyc(); #1;
    check("sat2_rdy", cmd_rdy, 0);
    check("sat2_mr_sat", mr_sat, 1);
    check("sat2_mr_we", mr_we, 1);
    check("sat2_done", done_vld, 1);
    check("sat2_tag", done_tag, 5);
    cyc(); #1;
    check("post_sat_rdy", cmd_rdy, 1);
    cyc(); cmd(1'b0, NOP, 4'd0); #1;
    check("mac_after_sat_e", arr_en, 1);
    check("mac_after_sat_mrsel", arr_mrsel, 2'b01);
    cyc(); cmd(1'b1, MAC, 4'd8); #1;
    check("mac_after_sat_tag", done_tag, 7);

    // Reset while MAC tag 8 is in E
    cyc(); cmd(1'b0, NOP, 4'd0); #1;
    check("pre_rst_arr_en", arr_en, 1);
    rst_n = 1'b0; #1;
    check("midrst_arr_en", arr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdy", cmd_rdy, 0);
    check("midrst_mrsel", arr_mrsel, 0);
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_done", done_vld, 0);
      check("post_rst_mr_we", mr_we, 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
